// File: rtl/snn_layer_tdm.sv
// rtl/snn_layer_tdm.sv - time-multiplexed LIF neuron layer with per-synapse delays
//
// One shared accumulator walks every synapse of every neuron once per timestep.
// Per neuron: LEAK (1 cycle), ACCUM (M cycles), FIRE (1 cycle); then DONE.
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   enable              0 freezes the FSM and all state
//   step_valid/ready    timestep handshake; ready = idle & enable
//   input_spikes [M]    spikes sampled at the handshake
//   weights [N*M*W]     signed weight n,m at [(n*M+m)*W +: W]
//   delay_values        delay n,m in steps at [(n*M+m)*DW +: DW]
//   threshold [VW]      signed firing threshold
//   decay [VW]          unsigned leak magnitude per step
//   refractory_period   steps skipped after a spike
//   output_spikes [N]   spike vector of the last completed step
//   out_valid           1-cycle pulse when output_spikes updates
//   busy                high outside IDLE
module snn_layer_tdm #(
  parameter int M    = 24,
  parameter int N    = 8,
  parameter int W    = 8,
  parameter int VW   = 12,
  parameter int DMAX = 8,
  localparam int DW  = $clog2(DMAX)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  step_valid,
  output logic                  step_ready,
  input  logic [M-1:0]          input_spikes,
  input  logic [N*M*W-1:0]      weights,
  input  logic [N*M*DW-1:0]     delay_values,
  input  logic signed [VW-1:0]  threshold,
  input  logic [VW-1:0]         decay,
  input  logic [7:0]            refractory_period,
  output logic [N-1:0]          output_spikes,
  output logic                  out_valid,
  output logic                  busy
);

  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int MW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [2:0] {IDLE, LEAK, ACCUM, FIRE, DONE} state_t;

  state_t state, state_nxt;

  logic [NW-1:0]         n_idx;
  logic [MW-1:0]         m_idx;
  logic                  skip;
  logic [N-1:0]          spk;
  logic signed [VW-1:0]  vm   [N];
  logic [7:0]            refr [N];
  logic [DMAX-1:0]       hist [M];

  logic                  handshake;
  logic signed [VW-1:0]  vm_cur;
  logic signed [VW:0]    vm_ext, dec_ext, leak_sum, acc_sum;
  logic signed [VW-1:0]  leak_val, acc_val;
  logic [W-1:0]          w_cur;
  logic [DW-1:0]         d_cur;
  logic                  spike_d;
  int                    syn;

  assign step_ready = (state == IDLE) && enable;
  assign busy       = (state != IDLE);
  assign handshake  = step_valid && step_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (step_valid) state_nxt = LEAK;
      LEAK:    state_nxt = ACCUM;
      ACCUM:   if (m_idx == MW'(M - 1)) state_nxt = FIRE;
      FIRE:    state_nxt = (n_idx == NW'(N - 1)) ? DONE : LEAK;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = state;
  end

  // Datapath operands for the synapse/neuron currently addressed.
  always_comb begin
    syn     = int'(n_idx) * M + int'(m_idx);
    w_cur   = weights[syn*W +: W];
    d_cur   = delay_values[syn*DW +: DW];
    spike_d = hist[m_idx][d_cur];
    vm_cur  = vm[n_idx];
    vm_ext  = {vm_cur[VW-1], vm_cur};
    dec_ext = {1'b0, decay};

    // Leak toward zero; a sign flip means the decay overshot, so clamp to 0.
    leak_val = vm_cur;
    leak_sum = vm_ext;
    if (vm_cur > 0) begin
      leak_sum = vm_ext - dec_ext;
      leak_val = leak_sum[VW] ? '0 : leak_sum[VW-1:0];
    end else if (vm_cur < 0) begin
      leak_sum = vm_ext + dec_ext;
      leak_val = leak_sum[VW] ? leak_sum[VW-1:0] : '0;
    end

    // One guard bit: the top two bits disagreeing means the sum left VW range.
    acc_sum = vm_ext + {{(VW+1-W){w_cur[W-1]}}, w_cur};
    if (acc_sum[VW] != acc_sum[VW-1])
      acc_val = acc_sum[VW] ? {1'b1, {(VW-1){1'b0}}} : {1'b0, {(VW-1){1'b1}}};
    else
      acc_val = acc_sum[VW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      n_idx         <= '0;
      m_idx         <= '0;
      skip          <= 1'b0;
      spk           <= '0;
      output_spikes <= '0;
      out_valid     <= 1'b0;
      for (int i = 0; i < N; i++) begin
        vm[i]   <= '0;
        refr[i] <= '0;
      end
      for (int i = 0; i < M; i++) hist[i] <= '0;
    end else if (enable) begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (handshake) begin
          for (int i = 0; i < M; i++)
            hist[i] <= {hist[i][DMAX-2:0], input_spikes[i]};
          n_idx <= '0;
          m_idx <= '0;
          spk   <= '0;
        end
        LEAK: begin
          m_idx <= '0;
          if (refr[n_idx] != 8'd0) begin
            refr[n_idx] <= refr[n_idx] - 8'd1;
            skip        <= 1'b1;
          end else begin
            vm[n_idx] <= leak_val;
            skip      <= 1'b0;
          end
        end
        ACCUM: begin
          if (!skip && spike_d) vm[n_idx] <= acc_val;
          m_idx <= (m_idx == MW'(M - 1)) ? '0 : m_idx + 1'b1;
        end
        FIRE: begin
          if (!skip && (vm_cur >= threshold)) begin
            spk[n_idx]  <= 1'b1;
            vm[n_idx]   <= '0;
            refr[n_idx] <= refractory_period;
          end
          n_idx <= (n_idx == NW'(N - 1)) ? '0 : n_idx + 1'b1;
        end
        DONE: begin
          output_spikes <= spk;
          out_valid     <= 1'b1;
        end
        default: ;
      endcase
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_snn_layer_tdm.sv
// tb/tb_snn_layer_tdm.sv - directed bench for snn_layer_tdm (M=4, N=2, DMAX=4)
module tb_snn_layer_tdm;

  localparam int M = 4, N = 2, W = 8, VW = 12, DMAX = 4, DW = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 enable = 1'b1;
  logic                 step_valid = 1'b0;
  logic                 step_ready;
  logic [M-1:0]         input_spikes = '0;
  logic [N*M*W-1:0]     weights = '0;
  logic [N*M*DW-1:0]    delay_values = '0;
  logic signed [VW-1:0] threshold = 12'sd35;
  logic [VW-1:0]        decay = '0;
  logic [7:0]           refractory_period = '0;
  logic [N-1:0]         output_spikes;
  logic                 out_valid;
  logic                 busy;

  int errors = 0;
  int checks = 0;

  snn_layer_tdm #(.M(M), .N(N), .W(W), .VW(VW), .DMAX(DMAX)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .step_valid(step_valid), .step_ready(step_ready),
    .input_spikes(input_spikes), .weights(weights), .delay_values(delay_values),
    .threshold(threshold), .decay(decay), .refractory_period(refractory_period),
    .output_spikes(output_spikes), .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_all_w(input logic [W-1:0] v);
    for (int i = 0; i < N*M; i++) weights[i*W +: W] = v;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); @(negedge clk); reset = 1'b0;
  endtask

  // Runs one timestep. lat counts clock edges from the handshake edge to the
  // edge that raises out_valid. Optional 5-cycle enable stall and a step_valid
  // poke while busy (-1 disables either).
  task automatic run_step(input logic [M-1:0] sp, input int stall_at, input int poke_at,
                          output logic [N-1:0] res, output int lat);
    @(negedge clk);
    input_spikes = sp;
    step_valid   = 1'b1;
    @(posedge clk);
    lat = 0;
    res = '0;
    while (lat < 200) begin
      @(negedge clk);
      if (lat == 0) step_valid = 1'b0;
      if (out_valid) break;
      if (lat == stall_at)     enable = 1'b0;
      if (lat == stall_at + 5) enable = 1'b1;
      if (lat == poke_at) begin
        check("ready_low_while_busy", step_ready, 0);
        step_valid = 1'b1;
      end
      if (lat == poke_at + 1) step_valid = 1'b0;
      lat++;
    end
    if (lat >= 200) check("step_timeout", lat, 0);
    res = output_spikes;
  endtask

  logic [N-1:0] res;
  int           lat, ov_count;
  logic [N-1:0] exp_s;

  initial begin
    // 1. reset state and mid-step abort
    do_reset();
    check("rst_spikes", output_spikes, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", step_ready, 1);

    set_all_w(8'd10);
    threshold = 12'sd45;
    @(negedge clk); input_spikes = 4'hF; step_valid = 1'b1;
    @(negedge clk); step_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("abort_busy", busy, 0);
    ov_count = 0;
    repeat (20) begin @(negedge clk); if (out_valid) ov_count++; end
    check("abort_no_out_valid", ov_count, 0);
    check("abort_ready", step_ready, 1);
    // vm must start from 0: 40 < 45, then 80 >= 45
    run_step(4'hF, -1, -1, res, lat);
    check("cleared_step1", res, 2'b00);
    run_step(4'hF, -1, -1, res, lat);
    check("cleared_step2", res, 2'b11);

    // 2. basic accumulate and latency
    do_reset();
    threshold = 12'sd35;
    run_step(4'hF, -1, -1, res, lat);
    check("basic_latency", lat, 13);
    check("basic_spikes", res, 2'b11);

    // 3. delayed spike
    do_reset();
    weights = '0; weights[0 +: W] = 8'd50;
    delay_values = '0; delay_values[0 +: DW] = 2'd2;
    threshold = 12'sd40;
    for (int s = 1; s <= 4; s++) begin
      run_step((s == 1) ? 4'b0001 : 4'b0000, -1, -1, res, lat);
      check($sformatf("delay_step%0d", s), res, (s == 3) ? 2'b01 : 2'b00);
    end

    // decay: 40 ; 40-15+40=65 ; 65-15+40=90 >= 70
    do_reset();
    delay_values = '0;
    set_all_w(8'd10);
    threshold = 12'sd70;
    decay = 12'd15;
    for (int s = 1; s <= 3; s++) begin
      run_step(4'hF, -1, -1, res, lat);
      check($sformatf("decay_step%0d", s), res, (s == 3) ? 2'b11 : 2'b00);
    end
    decay = '0;

    // 4. refractory period 2
    do_reset();
    threshold = 12'sd35;
    refractory_period = 8'd2;
    for (int s = 1; s <= 10; s++) begin
      run_step(4'hF, -1, -1, res, lat);
      exp_s = ((s - 1) % 3 == 0) ? 2'b11 : 2'b00;
      check($sformatf("refr_step%0d", s), res, exp_s);
    end
    refractory_period = 8'd0;

    // 5. negative saturation then climb to +2047
    do_reset();
    set_all_w(8'h80);
    threshold = 12'sd2047;
    for (int s = 1; s <= 10; s++) run_step(4'hF, -1, -1, res, lat);
    check("neg_sat_nospike", res, 2'b00);
    set_all_w(8'd127);
    // from -2048, +508 per step: 2016 after 8 steps, saturates to 2047 on step 9
    for (int s = 1; s <= 9; s++) begin
      run_step(4'hF, -1, -1, res, lat);
      check($sformatf("pos_sat_step%0d", s), res, (s == 9) ? 2'b11 : 2'b00);
    end

    // 6. enable stall in ACCUM and ignored step_valid while busy
    do_reset();
    set_all_w(8'd10);
    threshold = 12'sd35;
    run_step(4'hF, 3, 10, res, lat);
    check("stall_latency", lat, 18);
    check("stall_spikes", res, 2'b11);
    ov_count = 0;
    repeat (20) begin @(negedge clk); if (out_valid) ov_count++; end
    check("poke_ignored", ov_count, 0);
    check("poke_idle", busy, 0);
    run_step(4'hF, -1, -1, res, lat);
    check("after_stall_latency", lat, 13);
    check("after_stall_spikes", res, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
